rv32_csr_unit: RTL and testbench

Machine-mode control/status register file for the RV32IMZ core. Serves CSR instruction reads and writes, performs the mstatus, mepc, mcause and mtval updates for trap entry and MRET, and supplies the trap vector and return PC to the fetch stage. It also masks and prioritises interrupt requests, and keeps the 64-bit cycle and instret counters.

---
 rtl/rv32_csr_unit_pkg.sv | 79 +++++++
 rtl/rv32_csr_unit_irq_prio.sv | 32 +++
 rtl/rv32_csr_unit.sv | 186 ++++++++++++++++++
 tb/tb_rv32_csr_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_csr_unit_pkg.sv
// Shared CSR definitions for the RV32IMZ machine-mode CSR unit: addresses,
// instruction op encodings, fixed register values and interrupt indices.
package rv32_csr_unit_pkg;

    // Machine information registers (read-only)
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // Machine trap setup / handling
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;

    // Machine counters (writable) and their user-level shadows (read-only)
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // CSR instruction op field; the I-variants carry a pre-extended uimm
    typedef enum logic [2:0] {
        CSR_OP_NONE  = 3'd0,
        CSR_OP_RW    = 3'd1,
        CSR_OP_RS    = 3'd2,
        CSR_OP_RC    = 3'd3,
        CSR_OP_NONE4 = 3'd4,
        CSR_OP_RWI   = 3'd5,
        CSR_OP_RSI   = 3'd6,
        CSR_OP_RCI   = 3'd7
    } csr_op_e;

    // RV32, I extension only in the extension field
    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    // mstatus bit positions that are actually stored
    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    // Interrupt cause indices
    localparam int unsigned IRQ_MSI = 3;
    localparam int unsigned IRQ_MTI = 7;
    localparam int unsigned IRQ_MEI = 11;

    // Only MSI, MTI, MEI and the platform range 16..31 may raise an interrupt
    localparam logic [31:0] IRQ_ELIGIBLE_MASK = 32'hFFFF_0888;

    // True for the ops that write the CSR
    function automatic logic csr_op_writes(input csr_op_e op);
        return (op != CSR_OP_NONE) && (op != CSR_OP_NONE4);
    endfunction

    // New CSR value for a write/set/clear op given the current value
    function automatic logic [31:0] csr_write_value(input csr_op_e op,
                                                    input logic [31:0] old_value,
                                                    input logic [31:0] operand);
        logic [31:0] result;
        result = old_value;
        case (op)
            CSR_OP_RW, CSR_OP_RWI: result = operand;
            CSR_OP_RS, CSR_OP_RSI: result = old_value | operand;
            CSR_OP_RC, CSR_OP_RCI: result = old_value & ~operand;
            default:               result = old_value;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/rv32_csr_unit_irq_prio.sv
// Combinational interrupt priority encoder: MEI > MSI > MTI > platform
// interrupts 16..31 (lowest index first), gated by the global enable.
module rv32_csr_unit_irq_prio
    import rv32_csr_unit_pkg::*;
(
    input  logic [31:0] irq_masked,
    input  logic        global_ie,
    output logic        pending,
    output logic [31:0] cause
);

    logic [31:0] eligible;
    logic [4:0]  win_idx;

    // Pick the winning index; later assignments override earlier ones, so
    // the fixed-priority sources are applied last in increasing priority.
    always_comb begin
        eligible = irq_masked & IRQ_ELIGIBLE_MASK;
        pending  = global_ie & (|eligible);
        win_idx  = 5'd0;
        for (int i = 31; i >= 16; i--) begin
            if (eligible[i]) begin
                win_idx = 5'(i);
            end
        end
        if (eligible[IRQ_MTI]) win_idx = 5'(IRQ_MTI);
        if (eligible[IRQ_MSI]) win_idx = 5'(IRQ_MSI);
        if (eligible[IRQ_MEI]) win_idx = 5'(IRQ_MEI);
        cause = pending ? {1'b1, 26'd0, win_idx} : 32'd0;
    end

endmodule

// File: rtl/rv32_csr_unit.sv
// Machine-mode CSR file: CSR instruction reads/writes, trap entry / MRET
// state updates, interrupt masking and the 64-bit cycle/instret counters.
module rv32_csr_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [2:0]  csr_op,
    output logic [31:0] csr_rdata,
    output logic        csr_valid,
    input  logic        trap_entry,
    input  logic        trap_return,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_val,
    output logic [31:0] trap_vector,
    output logic [31:0] epc_out,
    input  logic [31:0] interrupts_i,
    output logic        interrupt_pending,
    output logic        interrupt_enabled,
    output logic [31:0] interrupt_cause,
    input  logic        instr_retired
);
    import rv32_csr_unit_pkg::*;

    // Architectural state
    logic        mstatus_mie_reg;
    logic        mstatus_mpie_reg;
    logic [31:0] mie_reg;
    logic [31:2] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:2] mepc_reg;
    logic [31:0] mcause_reg;
    logic [31:0] mtval_reg;
    logic [31:0] mip_reg;
    logic [63:0] mcycle_reg;
    logic [63:0] minstret_reg;
    logic [63:0] mcycle_next;
    logic [63:0] minstret_next;

    // Decoded write request
    csr_op_e     op_kind;
    logic        csr_we;
    logic [31:0] csr_wval;
    logic [31:0] mstatus_value;

    // The low PC bits are always cleared when saved into mepc
    logic        unused_trap_pc_lsbs;
    assign unused_trap_pc_lsbs = &{1'b0, trap_pc[1:0]};

    assign op_kind       = csr_op_e'(csr_op);
    assign mstatus_value = {24'd0, mstatus_mpie_reg, 3'd0, mstatus_mie_reg, 3'd0};

    // A trap or MRET in the same cycle swallows the CSR write completely
    assign csr_we   = csr_op_writes(op_kind) && !trap_entry && !trap_return;
    assign csr_wval = csr_write_value(op_kind, csr_rdata, csr_wdata);

    // Read mux: old value of the addressed CSR, zero for unimplemented ones
    always_comb begin
        csr_rdata = 32'd0;
        csr_valid = 1'b1;
        case (csr_addr)
            CSR_MVENDORID, CSR_MARCHID,
            CSR_MIMPID, CSR_MHARTID:      csr_rdata = 32'd0;
            CSR_MISA:                     csr_rdata = MISA_VALUE;
            CSR_MSTATUS:                  csr_rdata = mstatus_value;
            CSR_MIE:                      csr_rdata = mie_reg;
            CSR_MTVEC:                    csr_rdata = {mtvec_reg, 2'b00};
            CSR_MSCRATCH:                 csr_rdata = mscratch_reg;
            CSR_MEPC:                     csr_rdata = {mepc_reg, 2'b00};
            CSR_MCAUSE:                   csr_rdata = mcause_reg;
            CSR_MTVAL:                    csr_rdata = mtval_reg;
            CSR_MIP:                      csr_rdata = mip_reg;
            CSR_MCYCLE, CSR_CYCLE:        csr_rdata = mcycle_reg[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:      csr_rdata = mcycle_reg[63:32];
            CSR_MINSTRET, CSR_INSTRET:    csr_rdata = minstret_reg[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:  csr_rdata = minstret_reg[63:32];
            default: begin
                csr_rdata = 32'd0;
                csr_valid = 1'b0;
            end
        endcase
    end

    // mstatus: trap entry stacks MIE into MPIE, MRET restores it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
        end else if (trap_entry) begin
            mstatus_mpie_reg <= mstatus_mie_reg;
            mstatus_mie_reg  <= 1'b0;
        end else if (trap_return) begin
            mstatus_mie_reg  <= mstatus_mpie_reg;
            mstatus_mpie_reg <= 1'b1;
        end else if (csr_we && csr_addr == CSR_MSTATUS) begin
            mstatus_mie_reg  <= csr_wval[MSTATUS_MIE_BIT];
            mstatus_mpie_reg <= csr_wval[MSTATUS_MPIE_BIT];
        end
    end

    // Trap record registers: hardware capture on trap entry, else CSR writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mepc_reg   <= 30'd0;
            mcause_reg <= 32'd0;
            mtval_reg  <= 32'd0;
        end else if (trap_entry) begin
            mepc_reg   <= trap_pc[31:2];
            mcause_reg <= trap_cause;
            mtval_reg  <= trap_val;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MEPC:   mepc_reg   <= csr_wval[31:2];
                CSR_MCAUSE: mcause_reg <= csr_wval;
                CSR_MTVAL:  mtval_reg  <= csr_wval;
                default: ;
            endcase
        end
    end

    // Software-only registers: mie, mtvec (direct mode), mscratch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_reg      <= 32'd0;
            mtvec_reg    <= 30'd0;
            mscratch_reg <= 32'd0;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MIE:      mie_reg      <= csr_wval;
                CSR_MTVEC:    mtvec_reg    <= csr_wval[31:2];
                CSR_MSCRATCH: mscratch_reg <= csr_wval;
                default: ;
            endcase
        end
    end

    // mip samples the raw interrupt lines once per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mip_reg <= 32'd0;
        end else begin
            mip_reg <= interrupts_i;
        end
    end

    // Counter next values: a CSR write to either half replaces that half
    // and suppresses the increment of that counter for the cycle
    always_comb begin
        mcycle_next   = mcycle_reg + 64'd1;
        minstret_next = instr_retired ? (minstret_reg + 64'd1) : minstret_reg;
        if (csr_we) begin
            case (csr_addr)
                CSR_MCYCLE:    mcycle_next   = {mcycle_reg[63:32], csr_wval};
                CSR_MCYCLEH:   mcycle_next   = {csr_wval, mcycle_reg[31:0]};
                CSR_MINSTRET:  minstret_next = {minstret_reg[63:32], csr_wval};
                CSR_MINSTRETH: minstret_next = {csr_wval, minstret_reg[31:0]};
                default: ;
            endcase
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_reg   <= 64'd0;
            minstret_reg <= 64'd0;
        end else begin
            mcycle_reg   <= mcycle_next;
            minstret_reg <= minstret_next;
        end
    end

    // Fetch-stage redirect targets
    assign trap_vector       = {mtvec_reg, 2'b00};
    assign epc_out           = {mepc_reg, 2'b00};
    assign interrupt_enabled = mstatus_mie_reg;

    rv32_csr_unit_irq_prio u_csr_irq_prio (
        .irq_masked (mip_reg & mie_reg),
        .global_ie  (mstatus_mie_reg),
        .pending    (interrupt_pending),
        .cause      (interrupt_cause)
    );

endmodule

// File: tb/tb_rv32_csr_unit.sv
// Self-checking bench for rv32_csr_unit: directed steps followed by random
// traffic, all compared against a behavioural CSR model held in arrays.
module tb_rv32_csr_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [2:0]  csr_op = '0;
    logic [31:0] csr_rdata;
    logic        csr_valid;
    logic        trap_entry = 1'b0;
    logic        trap_return = 1'b0;
    logic [31:0] trap_pc = '0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_val = '0;
    logic [31:0] trap_vector;
    logic [31:0] epc_out;
    logic [31:0] interrupts_i = '0;
    logic        interrupt_pending;
    logic        interrupt_enabled;
    logic [31:0] interrupt_cause;
    logic        instr_retired = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    rv32_csr_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .csr_addr          (csr_addr),
        .csr_wdata         (csr_wdata),
        .csr_op            (csr_op),
        .csr_rdata         (csr_rdata),
        .csr_valid         (csr_valid),
        .trap_entry        (trap_entry),
        .trap_return       (trap_return),
        .trap_pc           (trap_pc),
        .trap_cause        (trap_cause),
        .trap_val          (trap_val),
        .trap_vector       (trap_vector),
        .epc_out           (epc_out),
        .interrupts_i      (interrupts_i),
        .interrupt_pending (interrupt_pending),
        .interrupt_enabled (interrupt_enabled),
        .interrupt_cause   (interrupt_cause),
        .instr_retired     (instr_retired)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Plain registers live in an address-keyed store with a writable-bit mask;
    // counters are kept as 64-bit numbers.
    logic [31:0] store [int];
    logic [31:0] wmask [int];
    logic [63:0] m_cycle;
    logic [63:0] m_instret;

    function automatic void model_reset();
        store.delete();
        wmask.delete();
        store['h301] = 32'h4000_0100; wmask['h301] = 32'h0;
        for (int a = 'hF11; a <= 'hF14; a++) begin
            store[a] = 32'h0; wmask[a] = 32'h0;
        end
        store['h300] = 0; wmask['h300] = 32'h0000_0088;
        store['h304] = 0; wmask['h304] = 32'hFFFF_FFFF;
        store['h305] = 0; wmask['h305] = 32'hFFFF_FFFC;
        store['h340] = 0; wmask['h340] = 32'hFFFF_FFFF;
        store['h341] = 0; wmask['h341] = 32'hFFFF_FFFC;
        store['h342] = 0; wmask['h342] = 32'hFFFF_FFFF;
        store['h343] = 0; wmask['h343] = 32'hFFFF_FFFF;
        store['h344] = 0; wmask['h344] = 32'h0;
        m_cycle   = 64'd0;
        m_instret = 64'd0;
    endfunction

    // Returns {implemented, value}
    function automatic logic [32:0] model_read(input logic [11:0] a);
        case (a)
            12'hB00, 12'hC00: return {1'b1, m_cycle[31:0]};
            12'hB80, 12'hC80: return {1'b1, m_cycle[63:32]};
            12'hB02, 12'hC02: return {1'b1, m_instret[31:0]};
            12'hB82, 12'hC82: return {1'b1, m_instret[63:32]};
            default: begin
                if (store.exists(int'(a))) return {1'b1, store[int'(a)]};
                return 33'd0;
            end
        endcase
    endfunction

    function automatic logic model_mie();
        logic [31:0] st;
        st = store['h300];
        return st[3];
    endfunction

    function automatic logic [31:0] model_irq_cause();
        logic [31:0] p;
        p = store['h344] & store['h304];
        if (!model_mie()) return 32'h0;
        if (p[11]) return 32'h8000_000B;
        if (p[3])  return 32'h8000_0003;
        if (p[7])  return 32'h8000_0007;
        for (int i = 16; i < 32; i++) begin
            if (p[i]) return 32'h8000_0000 | 32'(i);
        end
        return 32'h0;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven
    function automatic void model_clock();
        logic [32:0] rv;
        logic [31:0] old, nv, st;
        logic        wen, cyc_w, ins_w;
        int          a;
        a   = int'(csr_addr);
        rv  = model_read(csr_addr);
        old = rv[31:0];
        wen = rv[32] && (csr_op % 4 != 0) && !trap_entry && !trap_return;
        case (csr_op % 4)
            1: nv = csr_wdata;
            2: nv = old | csr_wdata;
            3: nv = old & ~csr_wdata;
            default: nv = old;
        endcase
        cyc_w = wen && (a == 'hB00 || a == 'hB80);
        ins_w = wen && (a == 'hB02 || a == 'hB82);
        if (!cyc_w)         m_cycle = m_cycle + 1;
        else if (a == 'hB00) m_cycle = {m_cycle[63:32], nv};
        else                 m_cycle = {nv, m_cycle[31:0]};
        if (!ins_w)          m_instret = m_instret + (instr_retired ? 1 : 0);
        else if (a == 'hB02) m_instret = {m_instret[63:32], nv};
        else                 m_instret = {nv, m_instret[31:0]};
        st = store['h300];
        if (trap_entry) begin
            store['h341] = trap_pc & 32'hFFFF_FFFC;
            store['h342] = trap_cause;
            store['h343] = trap_val;
            store['h300] = st[3] ? 32'h80 : 32'h00;
        end else if (trap_return) begin
            store['h300] = 32'h80 | (st[7] ? 32'h08 : 32'h00);
        end else if (wen && store.exists(a)) begin
            store[a] = (store[a] & ~wmask[a]) | (nv & wmask[a]);
        end
        store['h344] = interrupts_i;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [32:0] rv;
        logic [31:0] cause;
        rv    = model_read(csr_addr);
        cause = model_irq_cause();
        check($sformatf("rdata@%03h", csr_addr), csr_rdata, rv[31:0]);
        check($sformatf("valid@%03h", csr_addr), {31'd0, csr_valid}, {31'd0, rv[32]});
        check("trap_vector", trap_vector, store['h305]);
        check("epc_out", epc_out, store['h341]);
        check("int_pending", {31'd0, interrupt_pending}, {31'd0, cause != 0});
        check("int_enabled", {31'd0, interrupt_enabled}, {31'd0, model_mie()});
        check("int_cause", interrupt_cause, cause);
    endtask

    // Drive one cycle's inputs (called just after a falling edge) and check
    task automatic apply(input logic [11:0] a, input logic [2:0] op = 3'd0,
                         input logic [31:0] wd = 32'd0, input logic te = 1'b0,
                         input logic tr = 1'b0, input logic [31:0] tpc = 32'd0,
                         input logic [31:0] tca = 32'd0, input logic [31:0] tva = 32'd0);
        csr_addr    = a;
        csr_op      = op;
        csr_wdata   = wd;
        trap_entry  = te;
        trap_return = tr;
        trap_pc     = tpc;
        trap_cause  = tca;
        trap_val    = tva;
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic step(input logic [11:0] a, input logic [2:0] op = 3'd0,
                        input logic [31:0] wd = 32'd0);
        apply(a, op, wd);
        tick();
    endtask

    // Watchdog: the run must never hang
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    logic [11:0] addr_pool [0:24] = '{
        12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
        12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
        12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h300, 12'h304, 12'h341
    };

    initial begin
        // Reset state
        model_reset();
        csr_addr = 12'h305;
        repeat (2) @(negedge clk);
        #1;
        check_all();
        check("reset_trap_vector", trap_vector, 32'h0);
        check("reset_int_cause", interrupt_cause, 32'h0);
        rst_n = 1'b1;

        // misa and an unimplemented address
        apply(12'h301);
        check("misa", csr_rdata, 32'h4000_0100);
        check("misa_valid", {31'd0, csr_valid}, 32'd1);
        tick();
        apply(12'h7C0);
        check("unimpl_rdata", csr_rdata, 32'h0);
        check("unimpl_valid", {31'd0, csr_valid}, 32'd0);
        tick();

        // mstatus RW / RS / RC sequence
        step(12'h300, 3'd1, 32'h08);
        apply(12'h300); check("mstatus_rw", csr_rdata, 32'h08); tick();
        step(12'h300, 3'd2, 32'h80);
        apply(12'h300); check("mstatus_rs", csr_rdata, 32'h88); tick();
        step(12'h300, 3'd3, 32'h08);
        apply(12'h300); check("mstatus_rc", csr_rdata, 32'h80); tick();

        // Trap entry and MRET
        step(12'h305, 3'd1, 32'h1000);
        apply(12'h300); check("trap_vector", trap_vector, 32'h1000); tick();
        step(12'h300, 3'd1, 32'h08);
        apply(12'h341, 3'd0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h8000_000B, 32'h55);
        tick();
        apply(12'h341); check("mepc_trap", csr_rdata, 32'h100);
        check("epc_out_trap", epc_out, 32'h100); tick();
        apply(12'h342); check("mcause_trap", csr_rdata, 32'h8000_000B); tick();
        apply(12'h300); check("mstatus_trap", csr_rdata, 32'h80); tick();
        apply(12'h300, 3'd0, 32'h0, 1'b0, 1'b1); tick();
        apply(12'h300); check("mstatus_mret", csr_rdata, 32'h88);
        check("mie_after_mret", {31'd0, interrupt_enabled}, 32'd1); tick();

        // Interrupt masking and priority
        step(12'h304, 3'd1, 32'h80);
        interrupts_i = 32'h80;
        step(12'h344);
        step(12'h344);
        apply(12'h344);
        check("irq_pending_mti", {31'd0, interrupt_pending}, 32'd1);
        check("irq_cause_mti", interrupt_cause, 32'h8000_0007);
        tick();
        step(12'h304, 3'd2, 32'h800);
        interrupts_i = 32'h880;
        step(12'h344);
        apply(12'h344);
        check("irq_cause_mei", interrupt_cause, 32'h8000_000B);
        tick();
        interrupts_i = 32'h0;

        // Ten retirements from a cleared minstret
        step(12'hB02, 3'd1, 32'h0);
        step(12'hB82, 3'd1, 32'h0);
        instr_retired = 1'b1;
        repeat (10) step(12'hB00);
        instr_retired = 1'b0;
        apply(12'hB02); check("minstret_10", csr_rdata, 32'd10); tick();

        // Low-half overflow carries into the high half
        step(12'hB02, 3'd1, 32'hFFFF_FFFF);
        step(12'hB82, 3'd1, 32'h0);
        instr_retired = 1'b1;
        step(12'h340);
        instr_retired = 1'b0;
        apply(12'hB02); check("minstret_wrap_lo", csr_rdata, 32'h0); tick();
        apply(12'hB82); check("minstret_wrap_hi", csr_rdata, 32'h1); tick();

        // Trap entry wins over a coincident mepc write
        apply(12'h341, 3'd1, 32'h200, 1'b1, 1'b0, 32'h344, 32'h2, 32'h0);
        tick();
        apply(12'h341); check("mepc_collision", csr_rdata, 32'h344); tick();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [11:0] a;
            logic        te, tr;
            a  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, 24)];
            te = ($urandom_range(0, 15) == 0);
            tr = !te && ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) interrupts_i = $urandom & 32'hFFFF_0FFF;
            instr_retired = $urandom_range(0, 1) == 1;
            apply(a, 3'($urandom_range(0, 7)), $urandom, te, tr, $urandom, $urandom, $urandom);
            tick();
            if (n == 200) begin
                // Reset in the middle of operation clears everything at once
                step(12'h340, 3'd1, 32'hDEAD_BEEF);
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                check("midreset_epc", epc_out, 32'h0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        instr_retired = 1'b0;
        interrupts_i  = 32'h0;
        step(12'hB80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
